// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor stimulus generator: FSM state
// encoding, pattern/sensor sizing and the reference detector equation.
package sensor_pkg;

    localparam int NUM_PATTERNS = 16;
    localparam int SENSOR_W     = 4;
    localparam int ERR_W        = 5;
    localparam int DWELL_W      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Error flag a correct detector must raise for a given sensor pattern.
    function automatic logic expected_error(input logic [SENSOR_W-1:0] s);
        return s[0] | (s[1] & (s[2] | s[3]));
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the last cycle
// of each hold period on tc.
module dwell_timer
    import sensor_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [DWELL_W-1:0] count;

    assign tc = (count == DWELL_W'(DWELL - 1));

    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/sensor_stim.sv
// Sweeps all 16 sensor patterns into a detector, holding each for DWELL
// cycles and counting error_in responses. Optional self-check: SENSOR_STIM_SELFCHECK_EN.
module sensor_stim
    import sensor_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                error_in,
    output logic [SENSOR_W-1:0] sensors,
    output logic                busy,
    output logic                done,
    output logic [ERR_W-1:0]    err_count,
    output logic                mismatch
);

    state_t              state, state_next;
    logic [SENSOR_W-1:0] pattern, pattern_next;
    logic [ERR_W-1:0]    err_count_next;
    logic                dwell_tc;
    logic                sample;

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != DRIVE),
        .enable (state == DRIVE),
        .tc     (dwell_tc)
    );

    // A pattern is scored on the last cycle of its dwell period.
    assign sample = (state == DRIVE) && dwell_tc;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next     = state;
        pattern_next   = pattern;
        err_count_next = err_count;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next     = DRIVE;
                    pattern_next   = '0;
                    err_count_next = '0;
                end
            end
            DRIVE: begin
                if (sample) begin
                    if (error_in && (err_count != ERR_W'(NUM_PATTERNS))) begin
                        err_count_next = err_count + 1'b1;
                    end
                    if (pattern == SENSOR_W'(NUM_PATTERNS - 1)) begin
                        state_next = FINISH;
                    end else begin
                        pattern_next = pattern + 1'b1;
                    end
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they describe and never see error_in or start directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pattern   <= '0;
            err_count <= '0;
            sensors   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            pattern   <= pattern_next;
            err_count <= err_count_next;
            sensors   <= (state_next == DRIVE) ? pattern_next : '0;
            busy      <= (state_next == DRIVE);
            done      <= (state_next == FINISH);
        end
    end

`ifdef SENSOR_STIM_SELFCHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if ((state == IDLE) && start) begin
            mismatch <= 1'b0;
        end else if (sample && (error_in != expected_error(pattern))) begin
            mismatch <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_stim.sv
// Directed bench for sensor_stim: a DWELL=4 and a DWELL=1 instance driven by
// a behavioural detector with selectable faults, checked against hand-computed values.
module tb_sensor_stim;

    typedef enum int {CORRECT, STUCK1, STUCK0, S3FAULT} det_mode_t;

    typedef struct {
        int        sel;
        det_mode_t mode;
        int        restart_at;
        int        exp_done;
        int        exp_err;
        bit        exp_mm;
    } vec_t;

`ifdef SENSOR_STIM_SELFCHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0;
    logic       start1 = 1'b0;
    det_mode_t  mode = CORRECT;
    int         sel = 0;

    logic [3:0] sensors4, sensors1;
    logic       busy4, busy1, done4, done1, mm4, mm1;
    logic [4:0] err4, err1;
    logic       error_in4, error_in1;

    logic [3:0] o_sensors;
    logic       o_busy, o_done, o_mm;
    logic [4:0] o_err;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[8];

    always #5 clk = ~clk;

    // Behavioural detector under test, with planted faults.
    function automatic logic det(input det_mode_t m, input logic [3:0] s);
        case (m)
            CORRECT: return s[0] | (s[1] & (s[2] | s[3]));
            STUCK1:  return 1'b1;
            STUCK0:  return 1'b0;
            default: return s[0] | (s[1] & s[2]);
        endcase
    endfunction

    assign error_in4 = det(mode, sensors4);
    assign error_in1 = det(mode, sensors1);

    sensor_stim #(.DWELL(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .error_in(error_in4),
        .sensors(sensors4), .busy(busy4), .done(done4),
        .err_count(err4), .mismatch(mm4)
    );

    sensor_stim #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .error_in(error_in1),
        .sensors(sensors1), .busy(busy1), .done(done1),
        .err_count(err1), .mismatch(mm1)
    );

    always_comb begin
        o_sensors = (sel != 0) ? sensors1 : sensors4;
        o_busy    = (sel != 0) ? busy1    : busy4;
        o_done    = (sel != 0) ? done1    : done4;
        o_mm      = (sel != 0) ? mm1      : mm4;
        o_err     = (sel != 0) ? err1     : err4;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) start1 = v;
        else          start4 = v;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " sensors"},   32'(o_sensors), 0);
        check({tag, " busy"},      32'(o_busy),    0);
        check({tag, " done"},      32'(o_done),    0);
        check({tag, " err_count"}, 32'(o_err),     0);
        check({tag, " mismatch"},  32'(o_mm),      0);
    endtask

    // One full sweep, observed each cycle on the falling edge.
    task automatic do_vector(input vec_t v, input string tag);
        int k, done_at, busy_cycles, dw;
        bit seq_ok;
        sel = v.sel;
        mode = v.mode;
        dw = (v.sel != 0) ? 1 : 4;
        done_at = 0;
        busy_cycles = 0;
        seq_ok = 1'b1;
        set_start(1'b1);
        k = 0;
        while (k < 200 && done_at == 0) begin
            step(1);
            k++;
            set_start(k == v.restart_at);
            if (o_busy) begin
                busy_cycles++;
                if (o_sensors !== 4'((k - 1) / dw)) seq_ok = 1'b0;
            end
            if (o_done) done_at = k;
        end
        set_start(1'b0);
        check({tag, " done_at"},     32'(done_at),     32'(v.exp_done));
        check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(16 * dw));
        check({tag, " pattern_seq"}, 32'(seq_ok),      1);
        check({tag, " err_count"},   32'(o_err),       32'(v.exp_err));
        check({tag, " mismatch"},    32'(o_mm),        32'(v.exp_mm));
        check({tag, " finish_sensors"}, 32'(o_sensors), 0);
        step(1);
        check({tag, " done_pulse"},  32'(o_done), 0);
        check({tag, " idle_busy"},   32'(o_busy), 0);
        step(2);
        check({tag, " err_hold"},    32'(o_err),  32'(v.exp_err));
        check({tag, " mm_hold"},     32'(o_mm),   32'(v.exp_mm));
    endtask

    initial begin
        int k;

        vecs[0] = '{0, CORRECT, 0,  65, 11, 1'b0};
        vecs[1] = '{0, CORRECT, 10, 65, 11, 1'b0};
        vecs[2] = '{0, S3FAULT, 0,  65, 10, SC};
        vecs[3] = '{0, STUCK0,  0,  65, 0,  SC};
        vecs[4] = '{1, STUCK1,  0,  17, 16, SC};
        vecs[5] = '{1, CORRECT, 0,  17, 11, 1'b0};
        vecs[6] = '{1, S3FAULT, 0,  17, 10, SC};
        vecs[7] = '{1, STUCK1,  5,  17, 16, SC};

        // Reset state of both instances.
        rst = 1'b1;
        step(3);
        sel = 0; check_idle_zero("reset4");
        sel = 1; check_idle_zero("reset1");
        rst = 1'b0;
        step(1);

        foreach (vecs[i]) do_vector(vecs[i], $sformatf("vec%0d", i));

        // Reset wins over start in the same cycle.
        sel = 0;
        rst = 1'b1;
        set_start(1'b1);
        step(1);
        rst = 1'b0;
        set_start(1'b0);
        check("rst_prio busy", 32'(o_busy), 0);
        step(2);
        check("rst_prio stays_idle", 32'(o_busy), 0);

        // Reset in the middle of a DWELL=4 sweep, then a clean sweep.
        sel = 0;
        mode = STUCK1;
        set_start(1'b1);
        step(1);
        set_start(1'b0);
        step(19);
        check("midrst err_before", 32'(o_err),  4);
        check("midrst mm_before",  32'(o_mm),   32'(SC));
        check("midrst busy_before", 32'(o_busy), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_idle_zero("midrst");
        step(2);
        check("midrst idle_busy", 32'(o_busy), 0);
        do_vector('{0, CORRECT, 0, 65, 11, 1'b0}, "post_rst");

        // Detector ignoring s[3]: first disagreement is scored on pattern A.
        sel = 0;
        mode = S3FAULT;
        set_start(1'b1);
        step(1);
        set_start(1'b0);
        step(43);
        check("s3 sensors_A", 32'(o_sensors), 32'hA);
        check("s3 mm_on_A",   32'(o_mm),      0);
        step(1);
        check("s3 sensors_B", 32'(o_sensors), 32'hB);
        check("s3 mm_after_A", 32'(o_mm),     32'(SC));
        k = 45;
        while (k < 120 && !o_done) begin
            step(1);
            k++;
        end
        check("s3 done_at", 32'(k), 65);
        check("s3 err_count", 32'(o_err), 10);

        // start held through FINISH relaunches from the following IDLE cycle.
        step(2);
        sel = 1;
        mode = STUCK1;
        set_start(1'b1);
        step(1);
        step(16);
        check("hold done1",  32'(o_done), 1);
        check("hold err1",   32'(o_err),  16);
        mode = CORRECT;
        step(1);
        check("hold idle_busy", 32'(o_busy), 0);
        check("hold idle_done", 32'(o_done), 0);
        step(1);
        check("hold rebusy",    32'(o_busy), 1);
        check("hold err_clear", 32'(o_err),  0);
        check("hold mm_clear",  32'(o_mm),   0);
        set_start(1'b0);
        step(16);
        check("hold done2",  32'(o_done), 1);
        check("hold err2",   32'(o_err),  11);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sensor_stim.md
SENSOR_STIM -- requirements
Module: sensor_stim

Interface
REQ-001 Parameter: DWELL, default 4, clock cycles each test pattern is held on sensors (legal range 1..255).
REQ-002 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  level-sampled request to begin one full sweep.
REQ-005 Port: error_in  input  1  error flag returned by the detector under test.
REQ-006 Port: sensors  output  4  registered stimulus pattern driven to the detector.
REQ-007 Port: busy  output  1  high while a sweep is in progress.
REQ-008 Port: done  output  1  one-cycle pulse at sweep completion.
REQ-009 Port: err_count  output  5  number of patterns for which error_in was sampled high.
REQ-010 Port: mismatch  output  1  sticky self-check failure flag.

Function
REQ-011 FSM states SHALL be IDLE, DRIVE, FINISH; outputs are registered, with no combinational path from inputs to outputs.
REQ-012 IDLE: sensors=4'h0, busy=0, done=0; err_count and mismatch hold the previous sweep's values.
REQ-013 start=1 in IDLE SHALL move to DRIVE next edge, with pattern=0, dwell=0, err_count=0, mismatch=0.
REQ-014 start SHALL be ignored in DRIVE and FINISH; no restart and no counter clear.
REQ-015 DRIVE: sensors=pattern, busy=1; dwell increments each cycle.
REQ-016 When dwell==DWELL-1, error_in SHALL be sampled and err_count incremented by 1 if it is high; dwell returns to 0.
REQ-017 At that same edge, if pattern==4'hF, next state SHALL be FINISH; otherwise pattern increments by 1 (no wrap inside a sweep).
REQ-018 FINISH SHALL last exactly one cycle with done=1, busy=0, sensors=4'h0, then return to IDLE.
REQ-019 Timing: start sampled at edge T -> busy high for cycles T+1..T+16*DWELL -> done high in cycle T+16*DWELL+1.
REQ-020 err_count SHALL saturate at 5'd16 and never wrap.
REQ-021 start held high through FINISH SHALL launch a new sweep from the IDLE cycle that follows; there is no back-to-back start from FINISH.

Reset
REQ-022 rst=1 at any edge, including mid-sweep, SHALL force IDLE, sensors=0, busy=0, done=0, err_count=0, mismatch=0, pattern=0, dwell=0.
REQ-023 rst SHALL take priority over start in the same cycle.

Configuration
REQ-024 With SENSOR_STIM_SELFCHECK_EN defined, each sampled error_in SHALL be compared to expected = s[0] | (s[1] & (s[2] | s[3])); any difference sets mismatch until the next start or rst.
REQ-025 With SENSOR_STIM_SELFCHECK_EN undefined, the comparator SHALL be absent and mismatch tied to 0; all other behaviour is unchanged.

Structure
REQ-026 Shared package sensor_pkg SHALL hold the state enum, NUM_PATTERNS=16, SENSOR_W=4, and the expected-error function.
REQ-027 The dwell counter SHALL be a sub-module, dwell_timer, with inputs clear and enable, parameter DWELL, and a terminal-count output.

Verification
REQ-028 Correct detector model, DWELL=4, start pulse -> done at T+65, err_count=11, mismatch=0.
REQ-029 error_in stuck at 1, DWELL=1 -> done at T+17, err_count=16 (saturation), mismatch=1 when self-check is enabled.
REQ-030 rst asserted at cycle T+20 mid-sweep -> next cycle shows all outputs 0 and state IDLE; a new start runs a full 16-pattern sweep.
REQ-031 start re-pulsed at T+10 during a sweep -> no effect; done still at T+16*DWELL+1, err_count unchanged from the expected value.
REQ-032 Model with s[3] fault (detector ignores s[3]), self-check on -> mismatch=1 after pattern 4'h A, final err_count=10.
